// File: rtl/mdio_master_if.sv
// Request/response channel between register-interface control logic and the MDIO engine.
interface mdio_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_clause45;
   logic [1:0]  req_op;
   logic [4:0]  req_phy;
   logic [4:0]  req_reg;
   logic [15:0] req_data;
   logic        preamble_en;
   logic        resp_valid;
   logic [15:0] resp_data;
   logic        resp_err;
   logic        busy;

   // Requester side (control logic)
   modport master (
      output req_valid, req_clause45, req_op, req_phy, req_reg, req_data, preamble_en,
      input  req_ready, resp_valid, resp_data, resp_err, busy
   );

   // Engine side
   modport slave (
      input  req_valid, req_clause45, req_op, req_phy, req_reg, req_data, preamble_en,
      output req_ready, resp_valid, resp_data, resp_err, busy
   );
endinterface

// File: rtl/mdio_master.sv
// MDIO management master: generates MDC and serialises Clause 22 / Clause 45 frames.
module mdio_master #(
   parameter int unsigned CLK_DIV      = 25,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   mdio_master_if.slave bus,
   output logic         mdc,
   input  logic         mdio_i,
   output logic         mdio_o,
   output logic         mdio_t
);

   localparam int unsigned   DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
   localparam logic [6:0]    PreLast = 7'(PREAMBLE_LEN - 1);

   typedef enum logic [3:0] {
      StIdle, StPre, StSt, StOp, StPhy, StReg, StTa, StData, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic              phase_q, phase_d;
   logic [6:0]        bit_q, bit_d;
   logic [31:0]       frame_q, frame_d;
   logic              rd_q, rd_d;
   logic [15:0]       shift_q, shift_d;
   logic              ta_err_q, ta_err_d;
   logic [15:0]       resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;
   logic              sync1_q, sync2_q;
   logic              half_end, cell_end, released;
   logic [6:0]        field_last;

   // Two-flop synchroniser for the asynchronous pin input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= mdio_i;
         sync2_q <= sync1_q;
      end
   end

   // Engine state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         div_q       <= '0;
         phase_q     <= 1'b0;
         bit_q       <= '0;
         frame_q     <= '0;
         rd_q        <= 1'b0;
         shift_q     <= '0;
         ta_err_q    <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         frame_q     <= frame_d;
         rd_q        <= rd_d;
         shift_q     <= shift_d;
         ta_err_q    <= ta_err_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Index of the last bit of the field currently being sent
   always_comb begin
      field_last = '0;
      case (state_q)
         StPre:   field_last = PreLast;
         StSt:    field_last = 7'd1;
         StOp:    field_last = 7'd1;
         StPhy:   field_last = 7'd4;
         StReg:   field_last = 7'd4;
         StTa:    field_last = 7'd1;
         StData:  field_last = 7'd15;
         default: field_last = '0;
      endcase
   end

   // Next-state: accept, MDC divider, bit/field sequencing and read capture
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      frame_d     = frame_q;
      rd_d        = rd_q;
      shift_d     = shift_q;
      ta_err_d    = ta_err_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      half_end    = (div_q == DivMax);
      cell_end    = phase_q && half_end;

      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               div_d    = '0;
               phase_d  = 1'b0;
               bit_d    = '0;
               ta_err_d = 1'b0;
               // Whole post-preamble frame, shifted out MSB first; TA=10 only matters for writes
               frame_d  = {(bus.req_clause45 ? 2'b00 : 2'b01), bus.req_op, bus.req_phy,
                           bus.req_reg, 2'b10, bus.req_data};
               // Read ops are exactly those with OP[1] set in both clauses
               rd_d     = bus.req_op[1];
               if (!bus.req_clause45 && (bus.req_op == 2'b00 || bus.req_op == 2'b11)) begin
                  state_d    = StDone;
                  resp_err_d = 1'b1;
               end else begin
                  state_d = bus.preamble_en ? StPre : StSt;
               end
            end
         end
         StDone: state_d = StIdle;
         default: begin
            div_d = half_end ? '0 : div_q + 1'b1;
            if (half_end) begin
               phase_d = ~phase_q;
            end
            if (cell_end) begin
               // Sample point: last cycle of the MDC high phase
               if (rd_q && state_q == StTa && bit_q == 7'd1) begin
                  ta_err_d = sync2_q;
               end
               if (rd_q && state_q == StData) begin
                  shift_d = {shift_q[14:0], sync2_q};
               end
               if (state_q != StPre) begin
                  frame_d = {frame_q[30:0], 1'b0};
               end
               if (bit_q == field_last) begin
                  bit_d = '0;
                  case (state_q)
                     StPre:  state_d = StSt;
                     StSt:   state_d = StOp;
                     StOp:   state_d = StPhy;
                     StPhy:  state_d = StReg;
                     StReg:  state_d = StTa;
                     StTa:   state_d = StData;
                     StData: begin
                        state_d = StDone;
                        if (rd_q) begin
                           resp_data_d = shift_d;
                           resp_err_d  = ta_err_d;
                        end else begin
                           resp_err_d  = 1'b0;
                        end
                     end
                     default: state_d = StIdle;
                  endcase
               end else begin
                  bit_d = bit_q + 7'd1;
               end
            end
         end
      endcase
   end

   // Pin and handshake outputs decoded from registered state
   always_comb begin
      released       = rd_q && (state_q == StTa || state_q == StData);
      mdc            = phase_q;
      mdio_t         = (state_q == StIdle) || (state_q == StDone) || released;
      mdio_o         = 1'b1;
      if (state_q != StIdle && state_q != StDone && state_q != StPre && !released) begin
         mdio_o = frame_q[31];
      end
      bus.req_ready  = (state_q == StIdle);
      bus.busy       = (state_q != StIdle);
      bus.resp_valid = (state_q == StDone);
      bus.resp_data  = resp_data_q;
      bus.resp_err   = resp_err_q;
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master with CLK_DIV=4 and a 32-bit preamble.
module tb_mdio_master;

   localparam int unsigned ClkDiv = 4;
   localparam int unsigned PreLen = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mdc;
   logic mdio_i = 1'b1;
   logic mdio_o;
   logic mdio_t;

   int n_checks = 0;
   int n_fails  = 0;

   mdio_master_if bus ();

   mdio_master #(
      .CLK_DIV      (ClkDiv),
      .PREAMBLE_LEN (PreLen)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .mdc    (mdc),
      .mdio_i (mdio_i),
      .mdio_o (mdio_o),
      .mdio_t (mdio_t)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request; returns in cycle 1 after the accept edge
   task automatic issue(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] rg, input logic [15:0] data, input logic pre);
      chk("ready_before_req", 64'(bus.req_ready), 64'd1);
      bus.req_valid    = 1'b1;
      bus.req_clause45 = c45;
      bus.req_op       = op;
      bus.req_phy      = phy;
      bus.req_reg      = rg;
      bus.req_data     = data;
      bus.preamble_en  = pre;
      step();
   endtask

   // Run a frame cell by cell acting as the PHY, then check completion and return to idle
   task automatic run_frame(input string tag, input int nbits, input logic [63:0] exp_o,
                            input logic [63:0] exp_t, input logic [63:0] drv,
                            input logic [15:0] exp_data, input logic exp_err, input logic hold);
      logic [63:0] obs_o;
      logic [63:0] obs_t;
      int          bad_mdc;
      int          bad_stable;
      int          bad_hs;
      logic        o0;
      logic        t0;
      int          i;
      int          k;
      obs_o      = '0;
      obs_t      = '0;
      bad_mdc    = 0;
      bad_stable = 0;
      bad_hs     = 0;
      o0         = 1'b0;
      t0         = 1'b0;
      if (!hold) begin
         bus.req_valid = 1'b0;
      end
      // Fields change after accept and must be ignored
      bus.req_phy  = ~bus.req_phy;
      bus.req_reg  = ~bus.req_reg;
      bus.req_data = ~bus.req_data;
      for (int c = 1; c <= nbits * 2 * ClkDiv; c++) begin
         i = (c - 1) / (2 * ClkDiv);
         k = (c - 1) % (2 * ClkDiv);
         if (k == 0) begin
            mdio_i = drv[nbits - 1 - i];
            o0     = mdio_o;
            t0     = mdio_t;
            obs_o[nbits - 1 - i] = mdio_t ? 1'b0 : mdio_o;
            obs_t[nbits - 1 - i] = mdio_t;
         end else if (mdio_o !== o0 || mdio_t !== t0) begin
            bad_stable++;
         end
         if (mdc !== (k >= int'(ClkDiv))) bad_mdc++;
         if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) bad_hs++;
         step();
      end
      chk({tag, "_mdio_o"}, obs_o, exp_o);
      chk({tag, "_mdio_t"}, obs_t, exp_t);
      chk({tag, "_mdc_bad"}, 64'(bad_mdc), 64'd0);
      chk({tag, "_midcell_change"}, 64'(bad_stable), 64'd0);
      chk({tag, "_busy_hs_bad"}, 64'(bad_hs), 64'd0);
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd1);
      chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'(exp_err));
      chk({tag, "_resp_data"}, 64'(bus.resp_data), 64'(exp_data));
      chk({tag, "_done_pins"}, 64'({mdc, mdio_t, mdio_o}), 64'b011);
      mdio_i        = 1'b1;
      bus.req_valid = 1'b0;
      step();
      chk({tag, "_after_done"}, 64'({bus.req_ready, bus.busy, bus.resp_valid}), 64'b100);
   endtask

   initial begin
      int pulses;
      bus.req_valid    = 1'b0;
      bus.req_clause45 = 1'b0;
      bus.req_op       = 2'b00;
      bus.req_phy      = '0;
      bus.req_reg      = '0;
      bus.req_data     = '0;
      bus.preamble_en  = 1'b1;
      #1;
      chk("reset_ctrl", 64'({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err,
                             mdc, mdio_o, mdio_t}), 64'b1000011);
      chk("reset_data", 64'(bus.resp_data), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();

      // C22 write
      issue(1'b0, 2'b01, 5'd5, 5'h1F, 16'hA5C3, 1'b1);
      run_frame("c22_wr", 64,
                {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00101, 5'b11111, 2'b10, 16'hA5C3},
                64'h0, {64{1'b1}}, 16'h0000, 1'b0, 1'b0);

      // C22 read, PHY returns 0x1234
      issue(1'b0, 2'b10, 5'd5, 5'h02, 16'h0000, 1'b1);
      run_frame("c22_rd", 64,
                {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00101, 5'b00010, 18'b0},
                {46'b0, {18{1'b1}}}, {{46{1'b1}}, 2'b10, 16'h1234}, 16'h1234, 1'b0, 1'b0);

      // C22 read with no PHY
      issue(1'b0, 2'b10, 5'h0A, 5'h01, 16'h0000, 1'b1);
      run_frame("c22_nophy", 64,
                {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b01010, 5'b00001, 18'b0},
                {46'b0, {18{1'b1}}}, {64{1'b1}}, 16'hFFFF, 1'b1, 1'b0);

      // C45 address op without preamble; resp_data keeps previous read
      issue(1'b1, 2'b00, 5'd1, 5'd3, 16'h8001, 1'b0);
      run_frame("c45_addr", 32,
                {32'h0, 2'b00, 2'b00, 5'b00001, 5'b00011, 2'b10, 16'h8001},
                64'h0, {64{1'b1}}, 16'hFFFF, 1'b0, 1'b0);

      // Invalid C22 op 00: immediate error completion, no MDC activity
      issue(1'b0, 2'b00, 5'd1, 5'd1, 16'h1111, 1'b1);
      bus.req_valid = 1'b0;
      chk("inv_resp", 64'({bus.resp_valid, bus.resp_err, mdc, mdio_t}), 64'b1101);
      chk("inv_data", 64'(bus.resp_data), 64'hFFFF);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (mdc !== 1'b0 || mdio_t !== 1'b1 || bus.req_ready !== 1'b1) pulses++;
      end
      chk("inv_idle_after", 64'(pulses), 64'd0);

      // Reset during the DATA phase of a read
      issue(1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b1);
      bus.req_valid = 1'b0;
      repeat (51 * 2 * ClkDiv + 2) step();
      chk("rst_pre_in_data", 64'({bus.busy, mdio_t}), 64'b11);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_ctrl", 64'({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err,
                               mdc, mdio_o, mdio_t}), 64'b1000011);
      chk("rst_mid_data", 64'(bus.resp_data), 64'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) pulses++;
      end
      chk("rst_no_resp", 64'(pulses), 64'd0);

      // Read 0xBEEF with req_valid held for the whole frame
      issue(1'b0, 2'b10, 5'd3, 5'd4, 16'h0000, 1'b1);
      run_frame("c22_beef", 64,
                {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00011, 5'b00100, 18'b0},
                {46'b0, {18{1'b1}}}, {{46{1'b1}}, 2'b10, 16'hBEEF}, 16'hBEEF, 1'b0, 1'b1);
      step();
      chk("beef_no_reaccept", 64'({bus.req_ready, bus.busy, mdc}), 64'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
